// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both ends.
// Stage 1 holds the conditioned operands; stage 2 holds the result, bit-reversed A' and flags.
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   InA,
    input  logic [WIDTH-1:0]   InB,
    input  logic               Cin,
    input  logic [2:0]         Oper,
    input  logic               invA,
    input  logic               invB,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUout,
    output logic [WIDTH-1:0]   BTRout,
    output logic               seq,
    output logic               slt,
    output logic               sle,
    output logic               sco,
    output logic               beqz,
    output logic               bnez,
    output logic               bltz,
    output logic               bgez,
    output logic               Ofl,
    output logic [COUNT_W-1:0] op_count
);

    localparam int SH = $clog2(WIDTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [2:0]       s1_op;
    logic             s1_sign;

    logic adv2;
    logic adv1;
    logic accept;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    // Gated by reset so nothing is offered as accepted while the pipe is held clear
    assign in_ready = rst && adv1;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= '0;
            s1_sign  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a    <= invA ? ~InA : InA;
                s1_b    <= invB ? ~InB : InB;
                s1_cin  <= Cin;
                s1_op   <= Oper;
                s1_sign <= sign;
            end
        end
    end

    logic [SH-1:0]      amt;
    logic [2*WIDTH-1:0] rl_w;
    logic [2*WIDTH-1:0] rr_w;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   btr;
    logic               ovf_s;
    logic               ofl_n;

    always_comb begin
        amt   = s1_b[SH-1:0];
        rl_w  = {s1_a, s1_a} << amt;
        rr_w  = {s1_a, s1_a} >> amt;
        sum   = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
        ovf_s = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        res   = '0;
        case (s1_op)
            3'b000:  res = rl_w[2*WIDTH-1:WIDTH];
            3'b001:  res = s1_a << amt;
            3'b010:  res = rr_w[WIDTH-1:0];
            3'b011:  res = s1_a >> amt;
            3'b100:  res = sum[WIDTH-1:0];
            3'b101:  res = s1_a & s1_b;
            3'b110:  res = s1_a | s1_b;
            default: res = s1_a ^ s1_b;
        endcase
        ofl_n = (s1_op == 3'b100) ? (s1_sign ? ovf_s : sum[WIDTH]) : 1'b0;
        btr   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            btr[i] = s1_a[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            ALUout    <= '0;
            BTRout    <= '0;
            seq       <= 1'b0;
            slt       <= 1'b0;
            sle       <= 1'b0;
            sco       <= 1'b0;
            beqz      <= 1'b0;
            bnez      <= 1'b0;
            bltz      <= 1'b0;
            bgez      <= 1'b0;
            Ofl       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                ALUout <= res;
                BTRout <= btr;
                seq    <= (s1_a == s1_b);
                slt    <= ($signed(s1_a) <  $signed(s1_b));
                sle    <= ($signed(s1_a) <= $signed(s1_b));
                sco    <= sum[WIDTH];
                beqz   <= (s1_a == '0);
                bnez   <= (s1_a != '0);
                bltz   <= s1_a[WIDTH-1];
                bgez   <= !s1_a[WIDTH-1];
                Ofl    <= ofl_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
